// File: rtl/mem_stage.sv
// MEM pipeline stage: load/store bus sequencing, lane alignment and the MEM-WB register.
// Optional feature: define MEM_MISALIGN_TRAP_EN to abort misaligned LH/LHU/SH/LW/SW with bus_err_op.
package mem_stage_pkg;
  typedef enum logic [2:0] {LB, LH, LW, LBU, LHU, SB, SH, SW} load_store_func_code;
  typedef enum logic [1:0] {WB_ALU, WB_LOAD, WB_PC4, WB_UIMM} write_back_mux_selector;
endpackage

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   lsu_enable_ip,
  input  load_store_func_code    lsu_operator_ip,
  input  logic [31:0]            alu_result_ip,
  input  logic                   alu_valid_ip,
  input  logic [31:0]            mem_wdata_ip,
  input  write_back_mux_selector wb_mux_ip,
  input  logic [4:0]             write_reg_addr_ip,
  input  logic [31:0]            pc_addr_ip,
  input  logic [31:0]            uimmd_ip,
  output logic                   data_req_op,
  output logic [31:0]            data_addr_op,
  output logic                   data_we_op,
  output logic [3:0]             data_be_op,
  output logic [31:0]            data_wdata_op,
  input  logic                   data_gnt_ip,
  input  logic                   data_rvalid_ip,
  input  logic [31:0]            data_rdata_ip,
  output logic                   mem_stall_op,
  output logic [31:0]            fw_mem_data_op,
  output logic                   bus_err_op,
  output logic                   wb_valid_op,
  output logic [31:0]            wb_load_data_op,
  output logic [31:0]            wb_alu_result_op,
  output write_back_mux_selector wb_mux_op,
  output logic [4:0]             wb_write_reg_addr_op,
  output logic [31:0]            wb_pc_addr_op,
  output logic [31:0]            wb_uimmd_op
);
  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_n;
  logic [7:0]  cnt_q;
  logic [1:0]  ofs;
  logic        is_store, is_byte, is_half, trap, lsu_go, timeout;
  logic        done, load_done, err_n, wb_valid_n;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] load_data;

  assign ofs      = alu_result_ip[1:0];
  assign is_store = lsu_operator_ip inside {SB, SH, SW};
  assign is_byte  = lsu_operator_ip inside {LB, LBU, SB};
  assign is_half  = lsu_operator_ip inside {LH, LHU, SH};
  // Requests are masked while reset is high so nothing is issued before the first edge.
  assign lsu_go   = !reset && lsu_enable_ip && alu_valid_ip;
  // Abort on the TIMEOUT_CYCLES-th waiting cycle (counter starts at 0 on entry).
  assign timeout  = (cnt_q == TO_LAST);

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = is_half ? ofs[0] : (!is_byte && (ofs != 2'b00));
`else
  assign trap = 1'b0;
`endif

  assign data_addr_op   = {alu_result_ip[31:2], 2'b00};
  assign data_we_op     = is_store;
  assign fw_mem_data_op = alu_result_ip;

  always_comb begin
    data_be_op    = 4'b1111 << ofs;
    data_wdata_op = mem_wdata_ip;
    if (is_byte) begin
      data_be_op    = 4'b0001 << ofs;
      data_wdata_op = {4{mem_wdata_ip[7:0]}};
    end else if (is_half) begin
      data_be_op    = 4'b0011 << {ofs[1], 1'b0};
      data_wdata_op = {2{mem_wdata_ip[15:0]}};
    end
  end

  always_comb begin
    rbyte = data_rdata_ip[{ofs, 3'b000} +: 8];
    rhalf = ofs[1] ? data_rdata_ip[31:16] : data_rdata_ip[15:0];
    case (lsu_operator_ip)
      LB:      load_data = {{24{rbyte[7]}}, rbyte};
      LBU:     load_data = {24'd0, rbyte};
      LH:      load_data = {{16{rhalf[15]}}, rhalf};
      LHU:     load_data = {16'd0, rhalf};
      default: load_data = data_rdata_ip;
    endcase
  end

  always_comb begin
    state_n     = state_q;
    data_req_op = 1'b0;
    done        = 1'b0;
    load_done   = 1'b0;
    err_n       = 1'b0;
    case (state_q)
      IDLE: if (lsu_go) begin
        if (trap) err_n = 1'b1;
        else begin
          data_req_op = 1'b1;
          if (!data_gnt_ip) state_n = WAIT_GNT;
          else if (is_store) done = 1'b1;
          else state_n = WAIT_RVALID;
        end
      end
      WAIT_GNT: begin
        data_req_op = !reset;
        if (data_gnt_ip) begin
          done    = is_store;
          state_n = is_store ? IDLE : WAIT_RVALID;
        end else if (timeout) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end
      end
      WAIT_RVALID: begin
        if (data_rvalid_ip) begin
          done      = 1'b1;
          load_done = 1'b1;
          state_n   = IDLE;
        end else if (timeout) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // Stall exactly when the instruction stays in flight past this edge.
    mem_stall_op = (state_n != IDLE);
    wb_valid_n   = lsu_enable_ip ? done : alu_valid_ip;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q              <= IDLE;
      cnt_q                <= 8'd0;
      bus_err_op           <= 1'b0;
      wb_valid_op          <= 1'b0;
      wb_load_data_op      <= 32'd0;
      wb_alu_result_op     <= 32'd0;
      wb_mux_op            <= WB_ALU;
      wb_write_reg_addr_op <= 5'd0;
      wb_pc_addr_op        <= 32'd0;
      wb_uimmd_op          <= 32'd0;
    end else begin
      state_q              <= state_n;
      cnt_q                <= (state_n == IDLE || state_n != state_q) ? 8'd0 : cnt_q + 8'd1;
      bus_err_op           <= err_n;
      wb_valid_op          <= wb_valid_n;
      wb_alu_result_op     <= alu_result_ip;
      wb_mux_op            <= wb_mux_ip;
      wb_write_reg_addr_op <= write_reg_addr_ip;
      wb_pc_addr_op        <= pc_addr_ip;
      wb_uimmd_op          <= uimmd_ip;
      if (load_done) wb_load_data_op <= load_data;
    end
  end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of cycles spent waiting on the memory bus before aborting.
REQ-002 The block SHALL have these ports:
- clock  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-high reset
- lsu_enable_ip  input  1  instruction in MEM is a load/store
- lsu_operator_ip  input  load_store_func_code  LB/LH/LW/LBU/LHU/SB/SH/SW
- alu_result_ip  input  32  effective address or ALU result
- alu_valid_ip  input  1  alu_result_ip valid
- mem_wdata_ip  input  32  store data (rs2)
- wb_mux_ip  input  write_back_mux_selector  passed to WB
- write_reg_addr_ip  input  5  destination register
- pc_addr_ip  input  32  instruction PC
- uimmd_ip  input  32  upper immediate
- data_req_op  output  1  bus request
- data_addr_op  output  32  word-aligned address ({alu_result_ip[31:2],2'b00})
- data_we_op  output  1  1=store
- data_be_op  output  4  byte enables
- data_wdata_op  output  32  lane-aligned store data
- data_gnt_ip  input  1  request accepted
- data_rvalid_ip  input  1  read data valid
- data_rdata_ip  input  32  read data
- mem_stall_op  output  1  freeze IF/ID/EX
- fw_mem_data_op  output  32  forwarding value (= alu_result_ip, combinational)
- bus_err_op  output  1  one-cycle timeout/misalign pulse
- wb_valid_op, wb_load_data_op[31:0], wb_alu_result_op[31:0], wb_mux_op, wb_write_reg_addr_op[4:0], wb_pc_addr_op[31:0], wb_uimmd_op[31:0]  outputs  MEM-WB pipeline register
REQ-003 Clock and reset SHALL be one clock named clock and an asynchronous active-high reset named reset.

Function
REQ-004 The FSM SHALL have the states IDLE, WAIT_GNT and WAIT_RVALID.
REQ-005 For a non-LSU instruction (lsu_enable_ip=0), the block SHALL register the pass-through fields into MEM-WB in 1 cycle with wb_valid_op=alu_valid_ip and mem_stall_op=0.
REQ-006 In IDLE with lsu_enable_ip&&alu_valid_ip, the block SHALL assert data_req_op combinationally with address, we, be and wdata valid.
REQ-007 A store SHALL complete in the cycle data_gnt_ip=1 and stay in IDLE; with no gnt the FSM SHALL go to WAIT_GNT.
REQ-008 A load with gnt SHALL go to WAIT_RVALID, or to WAIT_GNT without gnt; WAIT_GNT SHALL go to WAIT_RVALID on gnt for a load, or to IDLE for a store.
REQ-009 WAIT_RVALID SHALL return to IDLE on data_rvalid_ip and register the extracted load data.
REQ-010 data_req_op SHALL be held high, with stable address, we, be and wdata, throughout WAIT_GNT and deasserted in WAIT_RVALID.
REQ-011 mem_stall_op SHALL be 1 in every cycle in which an accepted LSU instruction does not complete; upstream holds its inputs stable while stalled.
REQ-012 While stalled, the MEM-WB register SHALL capture a bubble (wb_valid_op=0); on the completion cycle it SHALL capture the instruction with wb_valid_op=1.
REQ-013 Byte enables SHALL be: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111.
REQ-014 Store data SHALL be: SB byte replicated ×4; SH half replicated ×2; SW as-is.
REQ-015 Load data SHALL be: LB/LBU rdata byte selected by addr[1:0], sign-/zero-extended; LH/LHU half selected by addr[1], sign-/zero-extended; LW as-is.
REQ-016 An 8-bit wait counter SHALL clear on entry to WAIT_GNT/WAIT_RVALID and increment each waiting cycle.
REQ-017 When the counter reaches TIMEOUT_CYCLES, the block SHALL pulse bus_err_op, return to IDLE, drop the request, capture wb_valid_op=0 and release stall.
REQ-018 data_rvalid_ip or data_gnt_ip arriving in IDLE without a request SHALL be ignored.

Reset
REQ-019 Reset SHALL asynchronously force state IDLE, counter 0, data_req_op=0, bus_err_op=0 and all MEM-WB outputs to 0 (wb_mux_op to its encoding 0), including mid-transaction.
REQ-020 The first request after reset deassertion SHALL be accepted no earlier than the first rising edge of clock.

Configuration
REQ-021 With MEM_MISALIGN_TRAP_EN defined, LH/LHU/SH with addr[0]=1 or LW/SW with addr[1:0]!=0 SHALL issue no request, pulse bus_err_op and capture wb_valid_op=0 in 1 cycle with no stall.
REQ-022 Without MEM_MISALIGN_TRAP_EN, misaligned accesses SHALL proceed using the lane selection of REQ-013 and REQ-015, with upper-lane overflow dropped and no error.

Verification
REQ-023 SW 0xDEADBEEF to 0x100 with gnt in the same cycle -> be=1111, we=1, wdata=0xDEADBEEF, stall=0, 1-cycle completion.
REQ-024 LB from 0x103 with gnt after 2 cycles and rvalid 1 cycle later, rdata=0x80FFFFFF -> stall for 3 cycles, wb_load_data_op=0xFFFFFF80, wb_valid_op=1.
REQ-025 SH 0x1234 to 0x202 -> be=1100, wdata=0x12341234.
REQ-026 A load that never receives rvalid with TIMEOUT_CYCLES=4 -> bus_err_op pulses 4 cycles after gnt, FSM returns to IDLE, stall drops, wb_valid_op=0.
REQ-027 Reset asserted in WAIT_GNT -> data_req_op=0 and state IDLE without a clock edge.
REQ-028 With MEM_MISALIGN_TRAP_EN, LW from 0x102 -> no data_req_op, bus_err_op=1 for 1 cycle; without the macro, LW from 0x102 issues a request with be=1100.
